// File: rtl/serial_rx.sv
// serial_rx -- asynchronous 8N1 serial receiver.
//
// Brings the asynchronous rx line into the clk domain through two flops.
// Detects the falling edge of the start bit and re-checks the start bit at its
// middle. Samples eight data bits LSB-first in the middle of each bit, then
// checks the stop bit. A completed byte is held on data with a level data_valid
// until the consumer acknowledges it.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset (0 = reset); release is
//                     synchronised to clk
//   rx           in   serial line, idle high, asynchronous to clk
//   data_ack     in   consumer has taken data; clears data_valid
//   data         out  last received byte
//   data_valid   out  high from byte completion until data_ack
//   frame_error  out  one-cycle pulse when the stop bit is sampled low
//   overrun      out  one-cycle pulse when a byte completes over an unread one
//   busy         out  high whenever the receiver is not idle

module serial_rx #(
  parameter int unsigned inputFrequency = 25000000,
  parameter int unsigned baudRate       = 115200,
  parameter int unsigned baudGenWidth   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  // One bit lasts baudMax+1 cycles so the receiver matches the transmitter's
  // bit timing exactly. The start bit is re-checked half a bit in, and every
  // later sample is one full bit after the previous one, so all samples land
  // mid-bit.
  localparam int unsigned baudMax    = inputFrequency / baudRate;
  localparam int unsigned bitCycles  = baudMax + 1;
  localparam int unsigned halfCycles = bitCycles / 2;

  localparam logic [baudGenWidth-1:0] bitLast  = baudGenWidth'(bitCycles - 1);
  localparam logic [baudGenWidth-1:0] halfLast = baudGenWidth'(halfCycles - 1);

  if (baudMax >= (64'd1 << baudGenWidth)) begin : gBadCounterWidth
    $error("serial_rx: baudMax does not fit in baudGenWidth bits");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } stateT;

  logic [1:0]              rstSync_q;
  logic                    rstN;

  logic                    rxMeta_q;
  logic                    rxs_q;
  logic                    rxsPrev_q;

  stateT                   state_q,       state_d;
  logic [baudGenWidth-1:0] cnt_q,         cnt_d;
  logic [2:0]              bitIdx_q,      bitIdx_d;
  logic [7:0]              shift_q,       shift_d;
  logic [7:0]              data_q,        data_d;
  logic                    dataValid_q,   dataValid_d;
  logic                    frameError_q,  frameError_d;
  logic                    overrun_q,     overrun_d;

  // Reset synchroniser. Assertion is immediate. Release reaches the rest of the
  // design only after two clean clock edges, so no flop leaves reset on a
  // marginal edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstN = rstSync_q[1];

  // Two-flop synchroniser for the line, plus one more stage that holds the
  // previous synchronised value for the falling-edge detector. All stages
  // reset to the idle level, so coming out of reset is never seen as a start
  // bit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxMeta_q  <= 1'b1;
      rxs_q     <= 1'b1;
      rxsPrev_q <= 1'b1;
    end else begin
      rxMeta_q  <= rx;
      rxs_q     <= rxMeta_q;
      rxsPrev_q <= rxs_q;
    end
  end

  // Receiver state and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bitIdx_q     <= 3'd0;
      shift_q      <= 8'h00;
      data_q       <= 8'h00;
      dataValid_q  <= 1'b0;
      frameError_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitIdx_q     <= bitIdx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      dataValid_q  <= dataValid_d;
      frameError_q <= frameError_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic.
  // The cycle counter runs freely and is cleared on each state transition.
  // data_valid is cleared by data_ack unless a byte completes in the same
  // cycle; in that case the completion sets data_valid again and wins.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + baudGenWidth'(1);
    bitIdx_d     = bitIdx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    dataValid_d  = dataValid_q & ~data_ack;
    frameError_d = 1'b0;
    overrun_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxsPrev_q && !rxs_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == halfLast) begin
          cnt_d = '0;
          // If the line is high again at mid start bit, the low was only a
          // glitch. Drop it without touching any output.
          if (!rxs_q) begin
            state_d  = S_DATA;
            bitIdx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == bitLast) begin
          cnt_d             = '0;
          shift_d[bitIdx_q] = rxs_q;
          if (bitIdx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (cnt_q == bitLast) begin
          cnt_d = '0;
          // Return to idle at mid stop bit. This leaves half a bit of slack,
          // so a start bit that follows a single stop bit is still caught.
          if (rxs_q) begin
            data_d      = shift_q;
            dataValid_d = 1'b1;
            overrun_d   = dataValid_q & ~data_ack;
            state_d     = S_IDLE;
          end else begin
            frameError_d = 1'b1;
            state_d      = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // Wait here until the line is high again. A long break therefore
        // reports only one framing error.
        cnt_d = '0;
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign data        = data_q;
  assign data_valid  = dataValid_q;
  assign frame_error = frameError_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx -- directed testbench for serial_rx at the default parameters
// (25 MHz clock, 218-cycle bit period).
// Frames are driven onto rx with a configurable bit period, given in
// hundredths of a cycle, so that skewed baud rates can be generated.

module tb_serial_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       data_ack;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int cycle       = 0;
  int checkCount  = 0;
  int passCount   = 0;
  int feCount     = 0;
  int ovCount     = 0;
  int busyCycles  = 0;
  int dvRiseCycle = 0;
  int frameStart  = 0;
  logic dvPrev    = 1'b0;

  serial_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_ack    (data_ack),
    .data        (data),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  // 10-unit clock period; cycle counts rising edges since time zero.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor, sampled on the falling edge. It counts output pulses and busy
  // cycles, and records when data_valid rises.
  always @(negedge clk) begin
    if (frame_error) feCount++;
    if (overrun) ovCount++;
    if (busy) busyCycles++;
    if (data_valid && !dvPrev) dvRiseCycle = cycle;
    dvPrev = data_valid;
  end

  // Global time limit in case something wedges.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic clearMonitors();
    feCount    = 0;
    ovCount    = 0;
    busyCycles = 0;
  endtask

  // Sends one frame: a start bit, 8 data bits LSB-first, then stopBits stop
  // bits. Bit k ends at round((k+1)*periodX100/100) cycles after the start
  // edge. If stopLowCycles > 0, the first stop bit is held low for that many
  // cycles instead.
  task automatic applyStimulus(input logic [7:0] value, input int periodX100,
                               input int stopBits, input int stopLowCycles);
    int   prevEnd;
    int   curEnd;
    logic bitVal;
    @(posedge clk); #1;
    frameStart = cycle;
    prevEnd    = 0;
    for (int k = 0; k < 9 + stopBits; k++) begin
      if (k == 0) bitVal = 1'b0;
      else if (k <= 8) bitVal = value[k-1];
      else if (k == 9 && stopLowCycles > 0) bitVal = 1'b0;
      else bitVal = 1'b1;
      rx = bitVal;
      curEnd = ((k + 1) * periodX100 + 50) / 100;
      if (k == 9 && stopLowCycles > 0) curEnd = prevEnd + stopLowCycles;
      repeat (curEnd - prevEnd) @(posedge clk);
      #1;
      prevEnd = curEnd;
    end
    rx = 1'b1;
  endtask

  task automatic ackByte();
    @(posedge clk); #1 data_ack = 1'b1;
    @(posedge clk); #1 data_ack = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int limit);
    int n = 0;
    while (!data_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, int'(data_valid), 1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte values and bit periods (in hundredths of a cycle) for the +/-3% cases.
  logic [7:0] skewByte [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
  int         skewPer  [4] = '{21165, 21165, 22474, 22474};

  initial begin
    int lat;
    int bad;
    reset    = 1'b0;
    rx       = 1'b1;
    data_ack = 1'b0;

    // Outputs while in reset.
    idleCycles(3);
    checkOutput("reset data", int'(data), 0);
    checkOutput("reset data_valid", int'(data_valid), 0);
    checkOutput("reset frame_error", int'(frame_error), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    checkOutput("reset busy", int'(busy), 0);
    reset = 1'b1;
    idleCycles(10);

    // Two bytes framed like the transmitter (two stop bits), each acknowledged.
    clearMonitors();
    applyStimulus(8'hA5, 21800, 2, 0);
    waitValid("t1 A5 valid", 50);
    checkOutput("t1 A5 data", int'(data), 'hA5);
    lat = dvRiseCycle - frameStart;
    checkOutput("t1 A5 latency", (lat >= 2072 && lat <= 2076) ? 2074 : lat, 2074);
    ackByte();
    checkOutput("t1 ack clears valid", int'(data_valid), 0);
    applyStimulus(8'h3C, 21800, 2, 0);
    waitValid("t1 3C valid", 50);
    checkOutput("t1 3C data", int'(data), 'h3C);
    lat = dvRiseCycle - frameStart;
    checkOutput("t1 3C latency", (lat >= 2072 && lat <= 2076) ? 2074 : lat, 2074);
    ackByte();
    checkOutput("t1 errors", feCount + ovCount, 0);

    // 50-cycle glitch on an idle line.
    clearMonitors();
    @(posedge clk); #1 rx = 1'b0;
    idleCycles(50);
    rx = 1'b1;
    idleCycles(300);
    checkOutput("t2 busy window", (busyCycles >= 105 && busyCycles <= 113) ? 109 : busyCycles, 109);
    checkOutput("t2 busy after", int'(busy), 0);
    checkOutput("t2 data_valid", int'(data_valid), 0);
    checkOutput("t2 errors", feCount + ovCount, 0);

    // Stop bit held low for 500 cycles, followed by a good frame.
    clearMonitors();
    applyStimulus(8'h81, 21800, 1, 500);
    idleCycles(20);
    checkOutput("t3 frame_error pulses", feCount, 1);
    checkOutput("t3 data_valid", int'(data_valid), 0);
    clearMonitors();
    applyStimulus(8'h42, 21800, 1, 0);
    waitValid("t3 42 valid", 50);
    checkOutput("t3 42 data", int'(data), 'h42);
    checkOutput("t3 42 frame_error", feCount, 0);
    ackByte();

    // Back-to-back bytes with no ack, which gives an overrun.
    clearMonitors();
    applyStimulus(8'h11, 21800, 1, 0);
    applyStimulus(8'h22, 21800, 1, 0);
    waitValid("t4 22 valid", 50);
    checkOutput("t4 overrun pulses", ovCount, 1);
    checkOutput("t4 data", int'(data), 'h22);
    // Third byte: ack arrives in the cycle the byte completes.
    clearMonitors();
    fork
      applyStimulus(8'h33, 21800, 1, 0);
      begin
        @(posedge clk); #1;
        repeat (2073) @(posedge clk);
        #1 data_ack = 1'b1;
        @(posedge clk); #1 data_ack = 1'b0;
      end
    join
    checkOutput("t4 same-cycle ack overrun", ovCount, 0);
    checkOutput("t4 same-cycle ack valid", int'(data_valid), 1);
    checkOutput("t4 33 data", int'(data), 'h33);
    ackByte();
    checkOutput("t4 ack clears valid", int'(data_valid), 0);
    ackByte();
    checkOutput("t4 idle ack valid", int'(data_valid), 0);
    checkOutput("t4 idle ack overrun", ovCount, 0);

    // Reset asserted during bit 3 of 0xFF.
    clearMonitors();
    fork
      applyStimulus(8'hFF, 21800, 1, 0);
      begin
        @(posedge clk); #1;
        repeat (980) @(posedge clk);
        #1;
        checkOutput("t5 busy before reset", int'(busy), 1);
        reset = 1'b0;
        #1;
        checkOutput("t5 async data", int'(data), 0);
        checkOutput("t5 async busy", int'(busy), 0);
        checkOutput("t5 async valid", int'(data_valid), 0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
      end
    join
    idleCycles(300);
    checkOutput("t5 no byte after reset", int'(data_valid), 0);
    applyStimulus(8'h5A, 21800, 1, 0);
    waitValid("t5 5A valid", 50);
    checkOutput("t5 5A data", int'(data), 'h5A);
    ackByte();

    // Skewed bit rates of +/-3%, which must be received correctly.
    for (int i = 0; i < 4; i++) begin
      clearMonitors();
      applyStimulus(skewByte[i], skewPer[i], 1, 0);
      waitValid($sformatf("t6 skew%0d valid", i), 50);
      checkOutput($sformatf("t6 skew%0d data", i), int'(data), int'(skewByte[i]));
      checkOutput($sformatf("t6 skew%0d frame_error", i), feCount, 0);
      ackByte();
    end

    // +/-6%: the frame must fail visibly, either as a frame error or as a wrong byte.
    for (int i = 0; i < 2; i++) begin
      clearMonitors();
      applyStimulus(8'h00, (i == 0) ? 20566 : 23191, 1, 0);
      idleCycles(50);
      bad = ((feCount > 0) || (data_valid && data != 8'h00)) ? 1 : 0;
      checkOutput($sformatf("t6 six-percent%0d detected", i), bad, 1);
      if (data_valid) ackByte();
      idleCycles(20);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
